// File: rtl/reg_pair_seq.sv
// ============================================================================
// Module   : reg_pair_seq
// Purpose  : 16-bit register-pair sequencer (read/write/inc/dec of BC, DE,
//            HL, AF) over an 8-bit two-read / one-write register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_pair_seq #(
    parameter logic [2:0] A_SEL    = 3'd7,
    parameter logic [2:0] IDLE_SEL = 3'd6,
    parameter logic [7:0] F_MASK   = 8'hF0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [1:0]  req_pair,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_data,
    input  logic [7:0]  flags_in,
    output logic [2:0]  rf_out1_sel,
    output logic [2:0]  rf_out2_sel,
    input  logic [7:0]  rf_out1,
    input  logic [7:0]  rf_out2,
    output logic [7:0]  rf_data_in,
    output logic [2:0]  rf_data_in_sel,
    output logic        rf_write_reg
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WR_LO = 3'd2,
        S_WR_HI = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    localparam logic [1:0] OP_READ = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_INC  = 2'd2;
    localparam logic [1:0] OP_DEC  = 2'd3;
    localparam logic [1:0] PAIR_AF = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [1:0]  pair_q, pair_d;
    logic [15:0] result_q, result_d;

    logic        w_is_af;
    logic [2:0]  w_hi_sel;
    logic [2:0]  w_lo_sel;
    logic [15:0] w_rd_value;

    // F lives outside the register file, so AF's low byte comes from flags_in.
    assign w_is_af    = (pair_q == PAIR_AF);
    assign w_hi_sel   = w_is_af ? A_SEL : {pair_q, 1'b0};
    assign w_lo_sel   = {pair_q, 1'b1};
    assign w_rd_value = {rf_out1, (w_is_af ? (flags_in & F_MASK) : rf_out2)};
    assign resp_data  = result_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= OP_READ;
            pair_q   <= 2'd0;
            result_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            pair_q   <= pair_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        pair_d         = pair_q;
        result_d       = result_q;
        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        rf_out1_sel    = IDLE_SEL;
        rf_out2_sel    = IDLE_SEL;
        rf_data_in     = 8'h00;
        rf_data_in_sel = 3'd0;
        rf_write_reg   = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d   = req_op;
                    pair_d = req_pair;
                    if (req_op == OP_WRITE) begin
                        result_d = req_wdata;
                        state_d  = S_WR_LO;
                    end else begin
                        state_d  = S_RD;
                    end
                end
            end
            S_RD: begin
                rf_out1_sel = w_hi_sel;
                rf_out2_sel = w_is_af ? IDLE_SEL : w_lo_sel;
                case (op_q)
                    OP_INC: begin
                        result_d = w_rd_value + 16'd1;
                        state_d  = S_WR_LO;
                    end
                    OP_DEC: begin
                        result_d = w_rd_value - 16'd1;
                        state_d  = S_WR_LO;
                    end
                    default: begin
                        result_d = w_rd_value;
                        state_d  = S_RESP;
                    end
                endcase
            end
            S_WR_LO: begin
                if (!w_is_af) begin
                    rf_write_reg   = 1'b1;
                    rf_data_in_sel = w_lo_sel;
                    rf_data_in     = result_q[7:0];
                end
                state_d = S_WR_HI;
            end
            S_WR_HI: begin
                rf_write_reg   = 1'b1;
                rf_data_in_sel = w_hi_sel;
                rf_data_in     = result_q[15:8];
                state_d        = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_pair_seq.sv
// ============================================================================
// Module   : tb_reg_pair_seq
// Purpose  : Self-checking bench for reg_pair_seq with a register-file model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_pair_seq;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [1:0]  req_pair = 2'd0;
    logic [15:0] req_wdata = 16'h0000;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_data;
    logic [7:0]  flags_in = 8'h00;
    logic [2:0]  rf_out1_sel;
    logic [2:0]  rf_out2_sel;
    logic [7:0]  rf_out1;
    logic [7:0]  rf_out2;
    logic [7:0]  rf_data_in;
    logic [2:0]  rf_data_in_sel;
    logic        rf_write_reg;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  rf_mem [8] = '{default: 8'h00};
    logic [7:0]  mdl    [8] = '{default: 8'h00};
    logic [15:0] last_resp;
    int          last_nstrobe;

    reg_pair_seq dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_pair       (req_pair),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .flags_in       (flags_in),
        .rf_out1_sel    (rf_out1_sel),
        .rf_out2_sel    (rf_out2_sel),
        .rf_out1        (rf_out1),
        .rf_out2        (rf_out2),
        .rf_data_in     (rf_data_in),
        .rf_data_in_sel (rf_data_in_sel),
        .rf_write_reg   (rf_write_reg)
    );

    always #5 clock = ~clock;

    // Register file: entry 6 is the never-written zero register.
    assign rf_out1 = rf_mem[rf_out1_sel];
    assign rf_out2 = rf_mem[rf_out2_sel];
    always @(posedge clock) begin
        if (rf_write_reg) rf_mem[rf_data_in_sel] <= rf_data_in;
    end

    // One complete transaction with model-derived expectations. When
    // do_release is 0 the response is left pending for the caller.
    task automatic test_transaction(input logic [1:0] op, input logic [1:0] pair,
                                    input logic [15:0] wdata, input bit do_release);
        logic [2:0]  hi, lo;
        logic [15:0] cur, res;
        logic [10:0] exp_w[$];
        logic [10:0] obs_w[$];
        int          exp_lat, lat, rd_n;
        logic [2:0]  rd_s1, rd_s2;
        bit          bad;

        hi  = (pair == 2'd3) ? 3'd7 : 3'(2 * pair);
        lo  = 3'(2 * pair + 1);
        cur = {mdl[hi], (pair == 2'd3) ? (flags_in & 8'hF0) : mdl[lo]};
        case (op)
            2'd0:    res = cur;
            2'd1:    res = wdata;
            2'd2:    res = cur + 16'd1;
            default: res = cur - 16'd1;
        endcase
        exp_lat = (op == 2'd0) ? 2 : (op == 2'd1) ? 3 : 4;
        if (op != 2'd0) begin
            if (pair != 2'd3) exp_w.push_back({lo, res[7:0]});
            exp_w.push_back({hi, res[15:8]});
        end

        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_op     = op;
        req_pair   = pair;
        req_wdata  = wdata;
        n_vec++;
        if (req_ready !== 1'b1) begin
            n_err++;
            $display("FAIL txn_ready: req_ready=%b required 1", req_ready);
        end
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_pair  = 2'($urandom);
        req_wdata = 16'($urandom);

        lat = 0; rd_n = 0; rd_s1 = 3'd0; rd_s2 = 3'd0;
        for (int k = 1; k <= 8; k++) begin
            if (rf_write_reg === 1'b1) obs_w.push_back({rf_data_in_sel, rf_data_in});
            if (rf_out1_sel !== 3'd6 || rf_out2_sel !== 3'd6) begin
                rd_n++; rd_s1 = rf_out1_sel; rd_s2 = rf_out2_sel;
            end
            if (resp_valid === 1'b1) begin
                lat = k;
                break;
            end
            @(negedge clock);
        end

        n_vec++;
        if (lat != exp_lat) begin
            n_err++;
            $display("FAIL txn_latency op=%0d pair=%0d: got %0d required %0d", op, pair, lat, exp_lat);
        end
        n_vec++;
        if (resp_data !== res) begin
            n_err++;
            $display("FAIL txn_data op=%0d pair=%0d: got %h required %h", op, pair, resp_data, res);
        end
        bad = (obs_w.size() != exp_w.size());
        if (!bad) foreach (exp_w[i]) if (obs_w[i] !== exp_w[i]) bad = 1'b1;
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL txn_strobes op=%0d pair=%0d: got %p required %p", op, pair, obs_w, exp_w);
        end
        n_vec++;
        if ((op == 2'd1) ? (rd_n != 0)
                         : (rd_n != 1 || rd_s1 !== hi || rd_s2 !== ((pair == 2'd3) ? 3'd6 : lo))) begin
            n_err++;
            $display("FAIL txn_rdsel op=%0d pair=%0d: got n=%0d sels %0d/%0d required hi %0d lo %0d",
                     op, pair, rd_n, rd_s1, rd_s2, hi, lo);
        end

        foreach (exp_w[i]) mdl[exp_w[i][10:8]] = exp_w[i][7:0];
        bad = 1'b0;
        for (int r = 0; r < 8; r++) if (rf_mem[r] !== mdl[r]) bad = 1'b1;
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL txn_regfile: got %p required %p", rf_mem, mdl);
        end
        last_resp    = resp_data;
        last_nstrobe = obs_w.size();

        if (do_release) begin
            resp_ready = 1'b1;
            @(posedge clock);
            @(negedge clock);
            resp_ready = 1'b0;
            n_vec++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL txn_release: ready=%b valid=%b required 1/0", req_ready, resp_valid);
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || rf_write_reg !== 1'b0 ||
            rf_out1_sel !== 3'd6 || rf_out2_sel !== 3'd6 || rf_data_in !== 8'h00 ||
            rf_data_in_sel !== 3'd0) begin
            n_err++;
            $display("FAIL reset_state: rdy=%b vld=%b wr=%b s1=%0d s2=%0d din=%h dsel=%0d required 1 0 0 6 6 00 0",
                     req_ready, resp_valid, rf_write_reg, rf_out1_sel, rf_out2_sel, rf_data_in, rf_data_in_sel);
        end
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_write();
        test_transaction(2'd1, 2'd2, 16'h1234, 1'b1);
        n_vec++;
        if (last_resp !== 16'h1234 || rf_mem[4] !== 8'h12 || rf_mem[5] !== 8'h34 || last_nstrobe != 2) begin
            n_err++;
            $display("FAIL write_hl: resp=%h H=%h L=%h strobes=%0d required 1234 12 34 2",
                     last_resp, rf_mem[4], rf_mem[5], last_nstrobe);
        end
    endtask

    task automatic test_read();
        test_transaction(2'd1, 2'd0, 16'hA55A, 1'b1);
        test_transaction(2'd0, 2'd0, 16'h0000, 1'b1);
        n_vec++;
        if (last_resp !== 16'hA55A || last_nstrobe != 0) begin
            n_err++;
            $display("FAIL read_bc: resp=%h strobes=%0d required a55a 0", last_resp, last_nstrobe);
        end
    endtask

    task automatic test_incdec_wrap();
        test_transaction(2'd1, 2'd1, 16'hFFFF, 1'b1);
        test_transaction(2'd2, 2'd1, 16'h0000, 1'b1);
        n_vec++;
        if (last_resp !== 16'h0000 || rf_mem[2] !== 8'h00 || rf_mem[3] !== 8'h00) begin
            n_err++;
            $display("FAIL inc_wrap: resp=%h D=%h E=%h required 0000 00 00", last_resp, rf_mem[2], rf_mem[3]);
        end
        test_transaction(2'd1, 2'd0, 16'h0000, 1'b1);
        test_transaction(2'd3, 2'd0, 16'h0000, 1'b1);
        n_vec++;
        if (last_resp !== 16'hFFFF) begin
            n_err++;
            $display("FAIL dec_wrap: resp=%h required ffff", last_resp);
        end
    endtask

    task automatic test_af();
        test_transaction(2'd1, 2'd3, 16'h1100, 1'b1);
        flags_in = 8'hBF;
        test_transaction(2'd0, 2'd3, 16'h0000, 1'b1);
        n_vec++;
        if (last_resp !== 16'h11B0) begin
            n_err++;
            $display("FAIL read_af: resp=%h required 11b0", last_resp);
        end
        test_transaction(2'd1, 2'd3, 16'h2233, 1'b1);
        n_vec++;
        if (last_resp !== 16'h2233 || last_nstrobe != 1 || rf_mem[7] !== 8'h22) begin
            n_err++;
            $display("FAIL write_af: resp=%h strobes=%0d A=%h required 2233 1 22",
                     last_resp, last_nstrobe, rf_mem[7]);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        test_transaction(2'd0, 2'd2, 16'h0000, 1'b0);
        held      = resp_data;
        req_valid = 1'b1;
        req_op    = 2'd0;
        req_pair  = 2'd1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            n_vec++;
            if (resp_valid !== 1'b1 || resp_data !== held || req_ready !== 1'b0) begin
                n_err++;
                $display("FAIL backpressure_hold c=%0d: vld=%b data=%h rdy=%b required 1 %h 0",
                         c, resp_valid, resp_data, req_ready, held);
            end
        end
        resp_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        resp_ready = 1'b0;
        n_vec++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL backpressure_release: rdy=%b vld=%b required 1 0", req_ready, resp_valid);
        end
        test_transaction(2'd0, 2'd1, 16'h0000, 1'b1);
    endtask

    task automatic test_reset_midstream();
        req_valid = 1'b1; req_op = 2'd1; req_pair = 2'd1; req_wdata = 16'hBEEF;
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        n_vec++;
        if (rf_write_reg !== 1'b1 || rf_data_in_sel !== 3'd3 || rf_data_in !== 8'hEF) begin
            n_err++;
            $display("FAIL midrst_wrlo: wr=%b sel=%0d din=%h required 1 3 ef", rf_write_reg, rf_data_in_sel, rf_data_in);
        end
        @(negedge clock);
        n_vec++;
        if (rf_write_reg !== 1'b1 || rf_data_in_sel !== 3'd2) begin
            n_err++;
            $display("FAIL midrst_wrhi: wr=%b sel=%0d required 1 2", rf_write_reg, rf_data_in_sel);
        end
        #1 reset_n = 1'b0;
        #1;
        n_vec++;
        if (rf_write_reg !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0 || rf_data_in !== 8'h00) begin
            n_err++;
            $display("FAIL midrst_async: wr=%b rdy=%b vld=%b din=%h required 0 1 0 00",
                     rf_write_reg, req_ready, resp_valid, rf_data_in);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        mdl[3] = 8'hEF;
        n_vec++;
        if (rf_mem[2] !== mdl[2] || rf_mem[3] !== 8'hEF || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_after: D=%h E=%h rdy=%b vld=%b required %h ef 1 0",
                     rf_mem[2], rf_mem[3], req_ready, resp_valid, mdl[2]);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            flags_in = 8'($urandom);
            test_transaction(2'($urandom), 2'($urandom), 16'($urandom), 1'b1);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_write();
        test_read();
        test_incdec_wrap();
        test_af();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
